// File: rtl/cam_rgb565_gray_pkg.sv
// Shared types and constants for the RGB565 camera byte stream to 8-bit luminance front end.
package cam_rgb565_gray_pkg;

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PIX_W   = 16;
  localparam int unsigned CH_W    = 8;
  localparam int unsigned SUM_W   = 16;
  localparam int unsigned GRAY_W  = 8;
  localparam int unsigned SYNC_DLY = 3;

  // Luminance weights sum to 256, so the weighted sum never exceeds 16 bits.
  localparam int unsigned COEF_R  = 77;
  localparam int unsigned COEF_G  = 150;
  localparam int unsigned COEF_B  = 29;
  localparam int unsigned Y_SHIFT = 8;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t to_rgb565(input logic [PIX_W-1:0] w);
    rgb565_t p;
    p.r = w[R_MSB:R_LSB];
    p.g = w[G_MSB:G_LSB];
    p.b = w[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/cam_rgb565_gray_if.sv
// Camera byte bus in, gray pixel stream with syncs out.
interface cam_rgb565_gray_if;
  import cam_rgb565_gray_pkg::*;

  logic              cam_vsync;
  logic              cam_href;
  logic              cam_byte_valid;
  logic [BYTE_W-1:0] cam_data;

  logic              gray_valid;
  logic [GRAY_W-1:0] gray_data;
  logic              hsync;
  logic              vsync;
  logic              line_err;
  logic              frame_done;

  modport master (
    output cam_vsync, cam_href, cam_byte_valid, cam_data,
    input  gray_valid, gray_data, hsync, vsync, line_err, frame_done
  );

  modport slave (
    input  cam_vsync, cam_href, cam_byte_valid, cam_data,
    output gray_valid, gray_data, hsync, vsync, line_err, frame_done
  );

endinterface

// File: rtl/cam_rgb565_gray_rgb565_to_gray.sv
// Three-stage RGB565 to luminance pipeline: expand+multiply, sum, shift into output register.
module rgb565_to_gray
  import cam_rgb565_gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  rgb565_t           pix,
  output logic              gray_valid,
  output logic [GRAY_W-1:0] gray
);

  logic [CH_W-1:0]  r8_c, g8_c, b8_c;
  logic             s1_valid, s2_valid;
  logic [SUM_W-1:0] prod_r, prod_g, prod_b;
  logic [SUM_W-1:0] sum;

  // Replicate the MSBs so full-scale 5/6-bit channels map to 255.
  always_comb begin
    r8_c = {pix.r, pix.r[4:2]};
    g8_c = {pix.g, pix.g[5:4]};
    b8_c = {pix.b, pix.b[4:2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      prod_r   <= '0;
      prod_g   <= '0;
      prod_b   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        prod_r <= SUM_W'(COEF_R) * SUM_W'(r8_c);
        prod_g <= SUM_W'(COEF_G) * SUM_W'(g8_c);
        prod_b <= SUM_W'(COEF_B) * SUM_W'(b8_c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum <= prod_r + prod_g + prod_b;
      end
    end
  end

  // Output data holds its last value between valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_valid <= 1'b0;
      gray       <= '0;
    end else begin
      gray_valid <= s2_valid;
      if (s2_valid) begin
        gray <= GRAY_W'(sum >> Y_SHIFT);
      end
    end
  end

endmodule

// File: rtl/cam_rgb565_gray.sv
// DVP camera front end: frame skip/arming FSM, byte-to-pixel assembly, geometry limits, sync delay.
module cam_rgb565_gray
  import cam_rgb565_gray_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 320,
  parameter int unsigned IMG_HEIGHT  = 240,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cam_rgb565_gray_if.slave bus
);

  localparam int unsigned COL_W  = $clog2(IMG_WIDTH + 2);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned SKIP_W = $clog2(SKIP_FRAMES + 2);
  localparam state_e      RST_STATE = (SKIP_FRAMES == 0) ? ST_ARMED : ST_SKIP;

  state_e              state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic                frame_done_q, frame_done_d;

  logic [SYNC_DLY-1:0] href_d, vsync_d;
  logic                href_rise, href_fall, vsync_rise, vsync_fall;

  logic                phase_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic                pix_ok;
  rgb565_t             pix_q;
  logic                pix_vld_q;
  logic                line_err_q;
  logic                gray_valid_q;
  logic [GRAY_W-1:0]   gray_q;

  // Edges are taken against the first tap of the sync delay line.
  assign href_rise  =  bus.cam_href  & ~href_d[0];
  assign href_fall  = ~bus.cam_href  &  href_d[0];
  assign vsync_rise =  bus.cam_vsync & ~vsync_d[0];
  assign vsync_fall = ~bus.cam_vsync &  vsync_d[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d  <= '0;
      vsync_d <= '0;
    end else begin
      href_d  <= {href_d[SYNC_DLY-2:0], bus.cam_href};
      vsync_d <= {vsync_d[SYNC_DLY-2:0], bus.cam_vsync};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      skip_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The falling edge that reaches the skip count is itself the start of the first forwarded frame.
  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_SKIP: begin
        if (vsync_fall) begin
          if (skip_q == SKIP_W'(SKIP_FRAMES)) begin
            state_d = ST_ACTIVE;
          end else begin
            skip_d = skip_q + SKIP_W'(1);
          end
        end
      end
      ST_ARMED: begin
        if (vsync_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (vsync_rise) begin
          state_d      = ST_ARMED;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  assign pix_ok = (state_q == ST_ACTIVE) &&
                  (col_q < COL_W'(IMG_WIDTH)) &&
                  (row_q < ROW_W'(IMG_HEIGHT));

  // A byte arriving with the href rise is the high byte of the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      hi_q      <= '0;
      col_q     <= '0;
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      pix_vld_q <= 1'b0;
      if (href_rise) begin
        col_q   <= '0;
        phase_q <= bus.cam_byte_valid;
        if (bus.cam_byte_valid) begin
          hi_q <= bus.cam_data;
        end
      end else if (bus.cam_href && bus.cam_byte_valid) begin
        if (!phase_q) begin
          hi_q    <= bus.cam_data;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          // Saturate one past the width so an overlong line still reads as malformed.
          if (col_q != COL_W'(IMG_WIDTH + 1)) begin
            col_q <= col_q + COL_W'(1);
          end
          if (pix_ok) begin
            pix_q     <= to_rgb565({hi_q, bus.cam_data});
            pix_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      line_err_q <= 1'b0;
    end else begin
      line_err_q <= href_fall && (state_q == ST_ACTIVE) &&
                    (phase_q || (col_q != COL_W'(IMG_WIDTH)));
      if (vsync_fall) begin
        row_q <= '0;
      end else if (href_fall && (row_q != ROW_W'(IMG_HEIGHT))) begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  rgb565_to_gray u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_vld_q),
    .pix        (pix_q),
    .gray_valid (gray_valid_q),
    .gray       (gray_q)
  );

  assign bus.gray_valid = gray_valid_q;
  assign bus.gray_data  = gray_q;
  assign bus.hsync      = href_d[SYNC_DLY-1];
  assign bus.vsync      = vsync_d[SYNC_DLY-1];
  assign bus.line_err   = line_err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_cam_rgb565_gray.sv
// Directed frame scenarios with random pixel data, checked against a frame/line/pixel reference model.
module tb_cam_rgb565_gray;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned SKIP = 2;
  localparam int          HN   = 16384;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  cam_rgb565_gray_if bus ();

  cam_rgb565_gray #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t         exp_px[$], obs_px[$];
  int          exp_le[$], obs_le[$], exp_fd[$], obs_fd[$];
  logic [15:0] pat[$];
  int          n_checks = 0, n_fail = 0;
  int          m_falls = 0, m_row = 0;
  bit          m_fwd = 1'b0;
  int          sync_from = 1 << 30;
  int          sync_bad = 0, lead_bad = 0;
  logic        hist_h[HN], hist_v[HN];
  logic        prev_hs = 1'b0;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    hist_h[cyc % HN] = bus.cam_href;
    hist_v[cyc % HN] = bus.cam_vsync;
    if (rst_n) begin
      if (bus.gray_valid) begin
        obs_px.push_back('{cyc, int'(bus.gray_data)});
        if (prev_hs !== 1'b1) lead_bad++;
      end
      if (bus.line_err)   obs_le.push_back(cyc);
      if (bus.frame_done) obs_fd.push_back(cyc);
      if (cyc >= sync_from &&
          (bus.hsync !== hist_h[(cyc - 3) % HN] || bus.vsync !== hist_v[(cyc - 3) % HN]))
        sync_bad++;
    end
    prev_hs = bus.hsync;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int gray_of(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic bv, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.cam_vsync      = vs;
    bus.cam_href       = hr;
    bus.cam_byte_valid = bv;
    bus.cam_data       = d;
  endtask

  task automatic do_reset();
    ev_t keep[$];
    rst_n = 1'b0;
    sync_from = 1 << 30;
    #1;
    chk("midrst_gray_valid", 32'(bus.gray_valid), 32'd0);
    chk("midrst_gray_data",  32'(bus.gray_data),  32'd0);
    chk("midrst_hsync",      32'(bus.hsync),      32'd0);
    chk("midrst_vsync",      32'(bus.vsync),      32'd0);
    chk("midrst_line_err",   32'(bus.line_err),   32'd0);
    chk("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    foreach (exp_px[i]) if (exp_px[i].cyc < cyc) keep.push_back(exp_px[i]);
    exp_px  = keep;
    m_falls = 0;
    m_fwd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync_from = cyc + 3;
  endtask

  task automatic send_line(input int nbytes, input bit gapped, input int lead, input int rst_at);
    logic [15:0] px;
    int npix;
    px = '0;
    npix = 0;
    for (int i = 0; i < lead; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int b = 0; b < nbytes; b++) begin
      if (gapped && b > 0) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
      if (b % 2 == 0) begin
        px = (pat.size() > 0) ? pat.pop_front() : 16'($urandom);
        drive(1'b0, 1'b1, 1'b1, px[15:8]);
      end else begin
        drive(1'b0, 1'b1, 1'b1, px[7:0]);
        if (m_fwd && npix < int'(W) && m_row < int'(H)) exp_px.push_back('{cyc + 4, gray_of(px)});
        npix++;
      end
      if (b == rst_at) do_reset();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    if (m_fwd && (nbytes % 2 == 1 || npix != int'(W))) exp_le.push_back(cyc + 1);
    m_row++;
    drive(1'b0, 1'b0, 1'b1, 8'($urandom));
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic begin_frame();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    m_falls++;
    m_fwd = (m_falls > int'(SKIP));
    m_row = 0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    if (m_fwd) exp_fd.push_back(cyc + 1);
    repeat (6) drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic random_frame();
    begin_frame();
    for (int l = 0; l < int'(H); l++)
      send_line(2 * int'(W), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
    end_frame();
  endtask

  task automatic check_all(input string tag);
    int n;
    chk({tag, "_px_count"}, 32'(obs_px.size()), 32'(exp_px.size()));
    n = (obs_px.size() < exp_px.size()) ? obs_px.size() : exp_px.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_px_cycle"}, 32'(obs_px[i].cyc), 32'(exp_px[i].cyc));
      chk({tag, "_px_gray"},  32'(obs_px[i].val), 32'(exp_px[i].val));
    end
    chk({tag, "_line_err_count"}, 32'(obs_le.size()), 32'(exp_le.size()));
    n = (obs_le.size() < exp_le.size()) ? obs_le.size() : exp_le.size();
    for (int i = 0; i < n; i++) chk({tag, "_line_err_cycle"}, 32'(obs_le[i]), 32'(exp_le[i]));
    chk({tag, "_frame_done_count"}, 32'(obs_fd.size()), 32'(exp_fd.size()));
    n = (obs_fd.size() < exp_fd.size()) ? obs_fd.size() : exp_fd.size();
    for (int i = 0; i < n; i++) chk({tag, "_frame_done_cycle"}, 32'(obs_fd[i]), 32'(exp_fd[i]));
    chk({tag, "_sync_delay"}, 32'(sync_bad), 32'd0);
    chk({tag, "_hsync_lead"}, 32'(lead_bad), 32'd0);
    exp_px.delete(); obs_px.delete();
    exp_le.delete(); obs_le.delete();
    exp_fd.delete(); obs_fd.delete();
  endtask

  initial begin
    int pat_gray[5];
    pat_gray = '{255, 76, 149, 28, 0};

    bus.cam_vsync      = 1'b1;
    bus.cam_href       = 1'b0;
    bus.cam_byte_valid = 1'b0;
    bus.cam_data       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gray_valid", 32'(bus.gray_valid), 32'd0);
    chk("rst_gray_data",  32'(bus.gray_data),  32'd0);
    chk("rst_hsync",      32'(bus.hsync),      32'd0);
    chk("rst_vsync",      32'(bus.vsync),      32'd0);
    chk("rst_line_err",   32'(bus.line_err),   32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    sync_from = cyc + 3;

    // Two discarded frames, then one forwarded full frame.
    repeat (3) random_frame();
    chk("skip_fwd_pixels", 32'(obs_px.size()), 32'(W * H));
    chk("skip_frame_done", 32'(obs_fd.size()), 32'd1);
    check_all("skip");

    // Known colours on the first line of a forwarded frame.
    pat = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h0000};
    begin_frame();
    send_line(2 * int'(W), 1'b0, 0, -1);
    for (int l = 1; l < int'(H); l++) send_line(2 * int'(W), 1'b0, 1, -1);
    end_frame();
    for (int i = 0; i < 5; i++) chk("pattern_gray", 32'(obs_px[i].val), 32'(pat_gray[i]));
    check_all("pattern");

    // Odd byte count, overlong, clean, short and one line past the frame height.
    begin_frame();
    send_line(2 * int'(W) + 1, 1'b0, 1, -1);
    send_line(2 * (int'(W) + 2), 1'b0, 0, -1);
    send_line(2 * int'(W), 1'b0, 2, -1);
    send_line(2 * (int'(W) - 3), 1'b1, 1, -1);
    send_line(2 * int'(W), 1'b0, 1, -1);
    end_frame();
    chk("malformed_line_errs", 32'(obs_le.size()), 32'd3);
    check_all("malformed");

    // Every byte separated by an idle cycle.
    begin_frame();
    for (int l = 0; l < int'(H); l++) send_line(2 * int'(W), 1'b1, l % 2, -1);
    end_frame();
    check_all("gapped");

    // Reset in the middle of a forwarded line, then the skip sequence restarts.
    begin_frame();
    send_line(2 * int'(W), 1'b0, 1, 9);
    send_line(2 * int'(W), 1'b0, 1, -1);
    end_frame();
    repeat (3) random_frame();
    chk("midrst_fwd_pixels", 32'(obs_px.size() - 2), 32'(W * H));
    check_all("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_rgb565_gray.md
# cam_rgb565_gray

Camera front end: takes the DVP byte stream from the image sensor (two bytes per RGB565 pixel), assembles pixels, converts them to 8-bit luminance in a 3-stage pipeline, and emits a gray pixel stream with aligned line and frame sync. Sits directly upstream of the Sobel edge stage and drives its `gray_valid`/`gray_data`/`hsync`/`vsync` inputs. Discards the first frames after reset while the sensor settles, and enforces the configured frame geometry.

## Interface
Parameters:
- `IMG_WIDTH`, 320, pixels per line forwarded
- `IMG_HEIGHT`, 240, lines per frame forwarded
- `SKIP_FRAMES`, 2, complete frames discarded after reset (0 allowed)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pixel-byte clock
- `rst_n`  in  1  asynchronous active-low reset
- `cam_vsync`  in  1  sensor frame sync, high between frames
- `cam_href`  in  1  sensor line active
- `cam_byte_valid`  in  1  `cam_data` valid this cycle
- `cam_data`  in  8  byte; high byte (R5,G6[5:3]) first, then low byte (G6[2:0],B5)
- `gray_valid`  out  1  `gray_data` valid
- `gray_data`  out  8  luminance
- `hsync`  out  1  `cam_href` delayed 3 cycles
- `vsync`  out  1  `cam_vsync` delayed 3 cycles
- `line_err`  out  1  1-cycle pulse: malformed line
- `frame_done`  out  1  1-cycle pulse: forwarded frame finished

## Operation
- Reset: all outputs 0; state SKIP (ARMED if `SKIP_FRAMES`=0); phase, col, row, skip counters 0.
- FSM:
  - SKIP: count `cam_vsync` falling edges; at count = `SKIP_FRAMES` go to ACTIVE (that falling edge starts the first forwarded frame).
  - ARMED: `cam_vsync` falling edge -> ACTIVE.
  - ACTIVE: `cam_vsync` rising edge -> ARMED, pulse `frame_done`.
- Byte phase: cleared on `cam_href` rising edge; toggles on each `cam_byte_valid` while `cam_href`=1. Phase 0 latches the high byte; phase 1 completes the pixel. Bytes with `cam_href`=0 are ignored.
- Pixel accepted only in ACTIVE with col < `IMG_WIDTH` and row < `IMG_HEIGHT`; col increments per completed pixel, clears on `cam_href` rising. Row increments on `cam_href` falling, clears on `cam_vsync` falling.
- `line_err` on `cam_href` falling (ACTIVE only) if phase = 1 or col != `IMG_WIDTH`. Surplus pixels dropped; short lines forwarded as-is.
- Conversion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; Y=(77·R8+150·G8+29·B8)>>8. Coefficients sum to 256; max sum 65280 fits 16 bits; no saturation needed, result ≤255.
- Outside ACTIVE, `gray_valid`=0 and `gray_data` holds its last value; `hsync`/`vsync` always follow the inputs.

## Timing
- Low byte sampled at edge k -> `gray_valid`=1 and `gray_data` valid in the cycle after edge k+3; 3-cycle fixed latency, fully pipelined, one pixel per 2 byte cycles max.
- `hsync`/`vsync` delayed 3 cycles so `hsync` rising precedes the line's first `gray_valid` by ≥1 cycle.
- Pipeline stages: S1 expand + three products, S2 16-bit sum, S3 shift into output register. Valid flag travels with data; no backpressure.
- `frame_done` in the cycle after the edge detecting `cam_vsync` rise; `line_err` in the cycle after `cam_href` fall detection.
- Simultaneous `cam_href` rise and `cam_byte_valid`: byte is phase 0 of the new line.
- Reset mid-frame: pipeline flushed, no further output until the next frame start per FSM (skip count restarts).

## Structure
- Shared package: FSM state enum (SKIP, ARMED, ACTIVE), luminance coefficients 77/150/29, shift 8, RGB565 field positions.
- Sub-module `rgb565_to_gray`: 3-stage pipeline, inputs pixel+valid, outputs gray+valid; top holds FSM, byte assembly, counters, sync delay.

## Test plan
- `SKIP_FRAMES`=2, three 320×240 frames -> no `gray_valid` for frames 1–2; frame 3 yields 76800 pixels, one `frame_done`.
- Pixels 0xFFFF, 0xF800, 0x07E0, 0x001F, 0x0000 -> gray 255, 76, 149, 28, 0, each 3 cycles after its low byte.
- Line with 641 bytes -> `line_err` pulse at line end, 320 pixels forwarded, last byte ignored.
- Line with 330 pixels -> 320 forwarded, `line_err`; next line clean, no error.
- Bytes gapped (`cam_byte_valid` every other cycle) -> identical gray values, `hsync` rise ≥1 cycle before first `gray_valid`.
- `rst_n` low mid-line -> outputs 0 immediately, no output until frame start after `SKIP_FRAMES` further frames.
